// File: rtl/hazard_if.sv
// hazard_if: signal bundle between the pipeline and the hazard controller
interface hazard_if #(
  parameter int REGFILE_LEN = 6,
  parameter int CNT_WIDTH   = 32
);
  logic                   ext_stall;
  logic [REGFILE_LEN-1:0] id_rs1, id_rs2;
  logic                   id_redirect;
  logic [REGFILE_LEN-1:0] ex_rs1, ex_rs2, ex_rd;
  logic                   ex_mem_read, ex_alu_fpu, ex_fpu_multi;
  logic                   mem_reg_write;
  logic [REGFILE_LEN-1:0] mem_rd;
  logic                   wb_reg_write;
  logic [REGFILE_LEN-1:0] wb_rd;
  logic                   pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall;
  logic                   if_id_flush, id_ex_flush, ex_mem_flush;
  logic [1:0]             fwd_a, fwd_b;
  logic                   fpu_busy;
  logic [CNT_WIDTH-1:0]   stall_count;
  modport master (
    output ext_stall, id_rs1, id_rs2, id_redirect, ex_rs1, ex_rs2, ex_rd,
           ex_mem_read, ex_alu_fpu, ex_fpu_multi, mem_reg_write, mem_rd, wb_reg_write, wb_rd,
    input  pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall,
           if_id_flush, id_ex_flush, ex_mem_flush, fwd_a, fwd_b, fpu_busy, stall_count
  );
  modport slave (
    input  ext_stall, id_rs1, id_rs2, id_redirect, ex_rs1, ex_rs2, ex_rd,
           ex_mem_read, ex_alu_fpu, ex_fpu_multi, mem_reg_write, mem_rd, wb_reg_write, wb_rd,
    output pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall,
           if_id_flush, id_ex_flush, ex_mem_flush, fwd_a, fwd_b, fpu_busy, stall_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forwarding control for the five-stage pipeline
module hazard_ctrl #(
  parameter int REGFILE_LEN = 6,
  parameter int FPU_LATENCY = 4,
  parameter int CNT_WIDTH   = 32
) (
  input  logic     clk,
  input  logic     rst,
  hazard_if.slave  bus
);
  localparam int CW = $clog2(FPU_LATENCY) + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(FPU_LATENCY > 1 ? FPU_LATENCY - 2 : 0);
  localparam logic FPU_EN = FPU_LATENCY > 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  localparam logic [REGFILE_LEN-1:0] R0 = '0;
  logic [0:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] stall_count_q, stall_count_d;
  logic fpu_start, fpu_stall, load_use, mem_ok, wb_ok;
  logic frz, fst, lus, red;
  assign fpu_start = state_q == IDLE && bus.ex_alu_fpu && bus.ex_fpu_multi && FPU_EN;
  assign fpu_stall = fpu_start || (state_q == BUSY && cnt_q != '0);
  assign load_use  = bus.ex_mem_read && bus.ex_rd != R0 && (bus.ex_rd == bus.id_rs1 || bus.ex_rd == bus.id_rs2);
  assign mem_ok    = bus.mem_reg_write && bus.mem_rd != R0;
  assign wb_ok     = bus.wb_reg_write && bus.wb_rd != R0;
  // prioritised hazard resolution; every control is forced low while in reset
  always_comb begin
    frz = rst && bus.ext_stall;
    fst = rst && !bus.ext_stall && fpu_stall;
    lus = rst && !bus.ext_stall && !fpu_stall && load_use;
    red = rst && !bus.ext_stall && !fpu_stall && !load_use && bus.id_redirect;
    bus.pc_stall     = frz || fst || lus;
    bus.if_id_stall  = frz || fst || lus;
    bus.id_ex_stall  = frz || fst;
    bus.ex_mem_stall = frz;
    bus.mem_wb_stall = frz;
    bus.if_id_flush  = red;
    bus.id_ex_flush  = lus;
    bus.ex_mem_flush = fst;
    bus.fwd_a = !rst ? 2'b00 : (mem_ok && bus.mem_rd == bus.ex_rs1) ? 2'b10 :
                (wb_ok && bus.wb_rd == bus.ex_rs1) ? 2'b01 : 2'b00;
    bus.fwd_b = !rst ? 2'b00 : (mem_ok && bus.mem_rd == bus.ex_rs2) ? 2'b10 :
                (wb_ok && bus.wb_rd == bus.ex_rs2) ? 2'b01 : 2'b00;
    bus.fpu_busy    = rst && state_q == BUSY;
    bus.stall_count = stall_count_q;
  end
  // FPU occupancy FSM and saturating stall counter; an external freeze holds the FSM
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!bus.ext_stall && fpu_start) begin
      state_d = BUSY;
      cnt_d   = CNT_LOAD;
    end else if (!bus.ext_stall && state_q == BUSY) begin
      cnt_d   = cnt_q != '0 ? cnt_q - CW'(1) : cnt_q;
      state_d = cnt_q != '0 ? BUSY : IDLE;
    end
    stall_count_d = bus.pc_stall && !(&stall_count_q) ? stall_count_q + CNT_WIDTH'(1) : stall_count_q;
  end
  // state registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stall_count_q <= stall_count_d;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and randomized checks of hazard_ctrl against a behavioural model
module tb_hazard_ctrl;
  localparam int RL = 6;
  localparam int L  = 4;
  localparam int CW = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  hazard_if #(.REGFILE_LEN(RL), .CNT_WIDTH(CW)) bus ();
  hazard_ctrl #(.REGFILE_LEN(RL), .FPU_LATENCY(L), .CNT_WIDTH(CW)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int errors = 0;
  logic          m_active = 1'b0;
  int            m_done   = 0;
  logic [CW-1:0] m_cnt    = '0;
  logic [12:0]   exp_v, dut_v;
  logic          exp_start;
  logic [31:0]   c0;
  function automatic logic [1:0] fwd(input logic [RL-1:0] rs, input logic mw, input logic [RL-1:0] mrd,
                                     input logic ww, input logic [RL-1:0] wrd);
    if (mw && mrd != 0 && mrd == rs) return 2'b10;
    if (ww && wrd != 0 && wrd == rs) return 2'b01;
    return 2'b00;
  endfunction
  // expected outputs: {5 stalls, 3 flushes, fwd_a, fwd_b, fpu_busy}
  always_comb begin
    logic fst, lu;
    logic [4:0] st;
    logic [2:0] fl;
    exp_start = bus.ex_alu_fpu && bus.ex_fpu_multi && (L > 1) && !m_active;
    fst = m_active ? (m_done < L - 1) : exp_start;
    lu  = bus.ex_mem_read && bus.ex_rd != 0 && (bus.ex_rd == bus.id_rs1 || bus.ex_rd == bus.id_rs2);
    st  = bus.ext_stall ? 5'b11111 : fst ? 5'b11100 : lu ? 5'b11000 : 5'b00000;
    fl  = bus.ext_stall ? 3'b000 : fst ? 3'b001 : lu ? 3'b010 : {bus.id_redirect, 2'b00};
    exp_v = rst ? {st, fl,
                   fwd(bus.ex_rs1, bus.mem_reg_write, bus.mem_rd, bus.wb_reg_write, bus.wb_rd),
                   fwd(bus.ex_rs2, bus.mem_reg_write, bus.mem_rd, bus.wb_reg_write, bus.wb_rd),
                   m_active} : 13'd0;
  end
  assign dut_v = {bus.pc_stall, bus.if_id_stall, bus.id_ex_stall, bus.ex_mem_stall, bus.mem_wb_stall,
                  bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush, bus.fwd_a, bus.fwd_b, bus.fpu_busy};
  // model: an FPU op counts unfrozen cycles since it started; it stalls for the first L-1 of them
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active <= 1'b0;
      m_done   <= 0;
      m_cnt    <= '0;
    end else begin
      if (exp_v[12] && m_cnt != '1) m_cnt <= m_cnt + 1;
      if (!bus.ext_stall) begin
        if (m_active) begin
          m_done   <= m_done + 1;
          m_active <= (m_done + 1 < L);
        end else if (exp_start) begin
          m_active <= 1'b1;
          m_done   <= 1;
        end
      end
    end
  end
  // per-cycle comparison against the model
  always @(negedge clk) begin
    checks += 1;
    if (dut_v !== exp_v) begin
      errors += 1;
      $display("FAIL cmp_outputs t=%0t got=%b exp=%b", $time, dut_v, exp_v);
    end
    checks += 1;
    if (bus.stall_count !== m_cnt) begin
      errors += 1;
      $display("FAIL cmp_stall_count t=%0t got=%0d exp=%0d", $time, bus.stall_count, m_cnt);
    end
  end
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks += 1;
    if (a !== e) begin
      errors += 1;
      $display("FAIL %s got=%0h exp=%0h", n, a, e);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic clear_in();
    bus.ext_stall = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_redirect = 0;
    bus.ex_rs1 = 0; bus.ex_rs2 = 0; bus.ex_rd = 0; bus.ex_mem_read = 0;
    bus.ex_alu_fpu = 0; bus.ex_fpu_multi = 0; bus.mem_reg_write = 0; bus.mem_rd = 0;
    bus.wb_reg_write = 0; bus.wb_rd = 0;
  endtask
  initial begin
    clear_in();
    rst = 1'b0;
    bus.ext_stall = 1;
    #3;
    chk("rst_mem_wb_stall", {31'd0, bus.mem_wb_stall}, 0);
    chk("rst_count", bus.stall_count, 0);
    step(); clear_in(); rst = 1'b1;
    step(); bus.ex_mem_read = 1; bus.ex_rd = 5; bus.id_rs2 = 5; #2;
    chk("lu_stalls", {27'd0, dut_v[12:8]}, 5'b11000);
    chk("lu_flush", {29'd0, dut_v[7:5]}, 3'b010);
    step(); bus.ex_rd = 0; bus.id_rs2 = 0; #2;
    chk("lu_r0_idle", {19'd0, dut_v}, 0);
    step(); clear_in(); bus.ex_alu_fpu = 1; bus.ex_fpu_multi = 1; #2;
    c0 = bus.stall_count;
    chk("fpu_c0", {27'd0, dut_v[12:8]}, 5'b11100);
    chk("fpu_c0_flush", {29'd0, dut_v[7:5]}, 3'b001);
    chk("fpu_c0_busy", {31'd0, bus.fpu_busy}, 0);
    step(); #2; chk("fpu_c1", {30'd0, bus.pc_stall, bus.fpu_busy}, 2'b11);
    step(); #2; chk("fpu_c2", {30'd0, bus.pc_stall, bus.fpu_busy}, 2'b11);
    step(); #2; chk("fpu_c3", {30'd0, bus.pc_stall, bus.fpu_busy}, 2'b01);
    step(); clear_in(); #2;
    chk("fpu_c4_busy", {31'd0, bus.fpu_busy}, 0);
    chk("fpu_count", bus.stall_count - c0, 3);
    step(); bus.ex_alu_fpu = 1; bus.ex_fpu_multi = 1;
    step(); bus.ext_stall = 1; #2;
    chk("frz_c1", {19'd0, dut_v[12:5], 2'b00, dut_v[4:0]}, {19'd0, 8'b11111000, 2'b00, 5'b00001});
    step(); #2; chk("frz_c2", {27'd0, dut_v[12:8]}, 5'b11111);
    step(); bus.ext_stall = 0; #2; chk("frz_c3", {24'd0, dut_v[12:5]}, 8'b11100001);
    step(); #2; chk("frz_c4", {24'd0, dut_v[12:5]}, 8'b11100001);
    step(); #2; chk("frz_c5", {30'd0, bus.pc_stall, bus.fpu_busy}, 2'b01);
    step(); clear_in();
    step(); bus.id_redirect = 1; bus.ex_mem_read = 1; bus.ex_rd = 3; bus.id_rs1 = 3; #2;
    chk("red_lu", {31'd0, bus.if_id_flush}, 0);
    step(); bus.ex_mem_read = 0; #2;
    chk("red_next", {31'd0, bus.if_id_flush}, 1);
    step(); clear_in(); bus.mem_rd = 7; bus.wb_rd = 7; bus.ex_rs1 = 7; bus.ex_rs2 = 7;
    bus.mem_reg_write = 1; bus.wb_reg_write = 1; #2;
    chk("fwd_mem", {28'd0, bus.fwd_a, bus.fwd_b}, 4'b1010);
    step(); bus.mem_reg_write = 0; #2;
    chk("fwd_wb", {30'd0, bus.fwd_a}, 2'b01);
    step(); bus.wb_rd = 0; bus.ex_rs1 = 0; #2;
    chk("fwd_r0", {30'd0, bus.fwd_a}, 2'b00);
    step(); clear_in(); bus.ex_alu_fpu = 1; bus.ex_fpu_multi = 1;
    step();
    step(); #2;
    rst = 1'b0; #1;
    chk("arst_busy", {31'd0, bus.fpu_busy}, 0);
    chk("arst_stall", {31'd0, bus.pc_stall}, 0);
    chk("arst_count", bus.stall_count, 0);
    step(); clear_in();
    step(); rst = 1'b1; #2;
    chk("arst_after", {19'd0, dut_v}, 0);
    for (int i = 0; i < 3000; i++) begin
      step();
      bus.ext_stall     = ($urandom % 8) == 0;
      bus.id_rs1        = RL'($urandom_range(0, 3));
      bus.id_rs2        = RL'($urandom_range(0, 3));
      bus.id_redirect   = ($urandom % 3) == 0;
      bus.ex_rs1        = RL'($urandom_range(0, 3));
      bus.ex_rs2        = RL'($urandom_range(0, 3));
      bus.ex_rd         = RL'($urandom_range(0, 3));
      bus.ex_mem_read   = $urandom % 2 == 1;
      bus.ex_alu_fpu    = ($urandom % 4) == 0;
      bus.ex_fpu_multi  = $urandom % 2 == 1;
      bus.mem_reg_write = $urandom % 2 == 1;
      bus.mem_rd        = RL'($urandom_range(0, 3));
      bus.wb_reg_write  = $urandom % 2 == 1;
      bus.wb_rd         = RL'($urandom_range(0, 3));
    end
    step(); clear_in();
    step(); step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised pipeline hazard controller for the five-stage core. It replaces the fixed, never-asserting stall unit. It generates per-stage stall and flush controls for the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC, and EX-stage operand forwarding selects. It covers four event sources:
- load-use hazards,
- control-flow redirects from ID,
- multi-cycle FPU operations,
- an external freeze request.

## Interface

Parameters:
- REGFILE_LEN, 6, register address width (address 0 is hardwired zero, never a hazard source).
- FPU_LATENCY, 4, cycles a multi-cycle FPU op occupies EX; a value of 1 disables FPU stalling.
- CNT_WIDTH, 32, width of the stall performance counter.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- ext_stall  in  1  external freeze request (debug or memory).
- id_rs1, id_rs2  in  REGFILE_LEN  source registers of the instruction in ID.
- id_redirect  in  1  imm_pc from ID: branch or jump taken.
- ex_rs1, ex_rs2, ex_rd  in  REGFILE_LEN  registers of the instruction in EX.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_alu_fpu, ex_fpu_multi  in  1  instruction in EX is an FPU op / is multi-cycle.
- mem_reg_write  in  1  write enable of the instruction in MEM.
- mem_rd  in  REGFILE_LEN  destination register of the instruction in MEM.
- wb_reg_write  in  1  write enable of the instruction in WB.
- wb_rd  in  REGFILE_LEN  destination register of the instruction in WB.
- pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall  out  1  hold the PC or pipeline register.
- if_id_flush, id_ex_flush, ex_mem_flush  out  1  load a bubble (all control bits 0) into the register.
- fwd_a, fwd_b  out  2  EX operand select: 00 = register file, 01 = WB data, 10 = MEM ALU result; 11 is never driven.
- fpu_busy  out  1  FSM is in BUSY.
- stall_count  out  CNT_WIDTH  number of cycles with pc_stall high; saturates at all-ones.

## Operation

- FSM states: IDLE and BUSY, with a down-counter cnt of width clog2(FPU_LATENCY)+1.
  - fpu_start = IDLE & ex_alu_fpu & ex_fpu_multi & (FPU_LATENCY > 1).
  - IDLE, fpu_start, !ext_stall: go to BUSY and load cnt with FPU_LATENCY-2.
  - BUSY, !ext_stall: if cnt != 0, decrement; if cnt == 0, go to IDLE.
  - ext_stall high: state and cnt hold.
- fpu_stall = fpu_start | (BUSY & cnt != 0).
- load_use = ex_mem_read & ex_rd != 0 & (ex_rd == id_rs1 | ex_rd == id_rs2).
- Priority is highest first. Outputs not listed under the winning case are 0.
  1. ext_stall: all five stalls are 1; no flushes.
  2. fpu_stall: pc, if_id and id_ex stalls are 1; ex_mem_flush is 1.
  3. load_use: pc and if_id stalls are 1; id_ex_flush is 1.
  4. id_redirect: if_id_flush is 1.
- A redirect that coincides with any higher-priority case is suppressed. The branch stays in ID and reasserts id_redirect the next cycle.
- Forwarding for fwd_a (fwd_b is identical using ex_rs2):
  - 10 when mem_reg_write & mem_rd != 0 & mem_rd == ex_rs1;
  - else 01 when wb_reg_write & wb_rd != 0 & wb_rd == ex_rs1;
  - else 00.
  - MEM takes priority over WB.
- Forwarding is combinational and independent of the stall outputs.
- stall_count increments on each edge where pc_stall is 1 and the count is below its maximum.

## Timing

- All stall, flush and forwarding outputs are combinational from the inputs and state. There is zero-cycle latency to the pipeline registers.
- A multi-cycle FPU op entering EX in cycle t produces stalls in cycles t through t+FPU_LATENCY-2, which is FPU_LATENCY-1 cycles. In cycle t+FPU_LATENCY-1 the stalls are low and the op advances to MEM at that edge.
- fpu_busy rises at t+1 and falls after cnt reaches 0.
- A load-use stall lasts exactly 1 cycle. At the next edge the load has moved to MEM, the bubble sits in EX, and the hazard has cleared.
- Reset (rst low) takes effect asynchronously, including in the middle of an FPU operation. While rst is low:
  - state = IDLE, cnt = 0, stall_count = 0;
  - all stall, flush, fwd and fpu_busy outputs are 0.
- Normal operation resumes on the first edge after rst deasserts.
- With FPU_LATENCY=1, fpu_start is constant 0 and the FSM never leaves IDLE.

## Test plan

- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5. Expect pc_stall=if_id_stall=id_ex_flush=1 for one cycle. Repeat with ex_rd=0 and expect all outputs 0.
- FPU latency: FPU_LATENCY=4, multi-cycle op in EX at cycle 0.
  - Stalls plus ex_mem_flush in cycles 0, 1 and 2; none in cycle 3.
  - fpu_busy high in cycles 1 to 3.
  - stall_count=3 afterwards.
- Freeze during FPU op: assert ext_stall during cycle 1 of the FPU op for 2 cycles. Expect all five stalls high and cnt frozen; FPU stalls resume with cycle count extended by 2.
- Redirect vs load-use: id_redirect=1 with load_use=1. Expect if_id_flush=0 that cycle and if_id_flush=1 the next cycle.
- Forwarding priority: mem_rd=wb_rd=ex_rs1=7 with both write enables high. Expect fwd_a=10. With mem_reg_write=0, expect fwd_a=01.
- Reset mid-operation: drop rst in BUSY with cnt=1. Expect fpu_busy=0 and all stalls 0 immediately (asynchronously), and stall_count=0.
